// File: rtl/rx_store_pkg.sv
// Shared types, constants and the ones-complement adder used by the
// receive/transmit data stores and the header builders.
package rx_store_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE,
        READ
    } state_t;

    localparam int CKSUM_W = 16;
    localparam int ADDR_W  = 8;

    // 16-bit add with the carry out folded back into bit 0.
    function automatic logic [CKSUM_W-1:0] cksum_add(input logic [CKSUM_W-1:0] a,
                                                     input logic [CKSUM_W-1:0] b);
        logic [CKSUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CKSUM_W-1:0] + {{(CKSUM_W-1){1'b0}}, s[CKSUM_W]};
    endfunction

endpackage

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// Dual-port block RAM, read-first, with an output register on both ports
// (two-cycle read latency). Port B carries the write.
module xilinx_true_dual_port_read_first_2_clock_ram #(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 256
) (
    input  logic                         clka,
    input  logic                         clkb,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dinb,
    input  logic                         ena,
    input  logic                         enb,
    input  logic                         web,
    input  logic                         rsta,
    input  logic                         rstb,
    input  logic                         regcea,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         douta,
    output logic [RAM_WIDTH-1:0]         doutb
);

    // NOTE: the array has no reset; block RAM cannot be cleared in a cycle and
    // the read-side valid pipeline already masks whatever it holds.
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_a_q, ram_data_b_q;
    logic [RAM_WIDTH-1:0] douta_q, doutb_q;

    always_ff @(posedge clkb) begin
        if (enb) begin
            if (web) mem[addrb] <= dinb;
            ram_data_b_q <= mem[addrb];
        end
    end

    always_ff @(posedge clka) begin
        if (ena) ram_data_a_q <= mem[addra];
    end

    // Output registers use the BRAM's synchronous, active-high reset.
    always_ff @(posedge clka) begin
        if (rsta)        douta_q <= '0;
        else if (regcea) douta_q <= ram_data_a_q;
    end

    always_ff @(posedge clkb) begin
        if (rstb)        doutb_q <= '0;
        else if (regceb) doutb_q <= ram_data_b_q;
    end

    assign douta = douta_q;
    assign doutb = doutb_q;

endmodule

// File: rtl/data_store_rx.sv
// Receive payload buffer: packs N-bit chunks into words in BRAM, tracks byte
// length and ones-complement sum, then drains the words on request.
module data_store_rx
    import rx_store_pkg::*;
#(
    parameter int N         = 2,
    parameter int DATA_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 axiiv,
    input  logic [N-1:0]         axiid,
    input  logic                 read_request,
    output logic                 axiov,
    output logic [DATA_SIZE-1:0] axiod,
    output logic                 axi_last,
    output logic                 frame_done,
    output logic [15:0]          data_sum,
    output logic [15:0]          data_length,
    output logic                 overflow
);

    localparam int DEPTH       = 256;
    localparam int WORD_CHUNKS = DATA_SIZE / N;
    localparam int CKS_CHUNKS  = CKSUM_W / N;
    localparam int WORD_BYTES  = DATA_SIZE / 8;
    localparam int CNT_W       = 5;
    localparam int IDX_W       = ADDR_W + 1;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     wcnt_q, wcnt_d, wcnt_b;
    logic [CNT_W-1:0]     ccnt_q, ccnt_d, ccnt_b;
    logic [DATA_SIZE-1:0] word_sr_q, word_sr_d, word_tail;
    logic [CKSUM_W-1:0]   cks_sr_q, cks_sr_d, cks_tail;
    logic [CKSUM_W-1:0]   sum_q, sum_d, sum_b;
    logic [IDX_W-1:0]     widx_q, widx_d, widx_b;
    logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
    logic [15:0]          len_q, len_d, len_b;
    logic                 ovf_q, ovf_d, ovf_b;
    logic                 frame_done_q, frame_done_d;
    logic                 vld1_q, vld1_d, vld2_q, vld2_d;
    logic                 last1_q, last1_d, last2_q, last2_d;
    logic                 start;
    int                   w_bytes, c_bytes;

    logic                 ram_web, ram_ena;
    logic [ADDR_W-1:0]    ram_addrb;
    logic [DATA_SIZE-1:0] ram_dinb, ram_douta, doutb_unused;

    xilinx_true_dual_port_read_first_2_clock_ram #(
        .RAM_WIDTH(DATA_SIZE),
        .RAM_DEPTH(DEPTH)
    ) u_ram (
        .clka  (clk),
        .clkb  (clk),
        .addra (rd_idx_q[ADDR_W-1:0]),
        .addrb (ram_addrb),
        .dinb  (ram_dinb),
        .ena   (ram_ena),
        .enb   (1'b1),
        .web   (ram_web),
        .rsta  (~rst),
        .rstb  (~rst),
        .regcea(1'b1),
        .regceb(1'b1),
        .douta (ram_douta),
        .doutb (doutb_unused)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            ccnt_q       <= '0;
            word_sr_q    <= '0;
            cks_sr_q     <= '0;
            sum_q        <= '0;
            widx_q       <= '0;
            rd_idx_q     <= '0;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
            vld1_q       <= 1'b0;
            vld2_q       <= 1'b0;
            last1_q      <= 1'b0;
            last2_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            ccnt_q       <= ccnt_d;
            word_sr_q    <= word_sr_d;
            cks_sr_q     <= cks_sr_d;
            sum_q        <= sum_d;
            widx_q       <= widx_d;
            rd_idx_q     <= rd_idx_d;
            len_q        <= len_d;
            ovf_q        <= ovf_d;
            frame_done_q <= frame_done_d;
            vld1_q       <= vld1_d;
            vld2_q       <= vld2_d;
            last1_q      <= last1_d;
            last2_q      <= last2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (axiiv) state_d = RECV;
            RECV: if (!axiiv) state_d = DONE;
            DONE: begin
                if (axiiv)                                 state_d = RECV;
                else if (read_request && widx_q != '0)     state_d = READ;
            end
            READ: begin
                if (axiiv)                 state_d = RECV;
                else if (vld2_q && last2_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Packer and checksum. A chunk seen outside RECV is the first chunk of a
    // new frame, so it is folded into freshly cleared counters.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        start     = axiiv && (state_q != RECV);
        wcnt_b    = start ? '0 : wcnt_q;
        ccnt_b    = start ? '0 : ccnt_q;
        widx_b    = start ? '0 : widx_q;
        len_b     = start ? '0 : len_q;
        sum_b     = start ? '0 : sum_q;
        ovf_b     = start ? 1'b0 : ovf_q;
        wcnt_d    = wcnt_b;
        ccnt_d    = ccnt_b;
        widx_d    = widx_b;
        len_d     = len_b;
        sum_d     = sum_b;
        ovf_d     = ovf_b;
        word_sr_d = word_sr_q;
        cks_sr_d  = cks_sr_q;
        ram_web   = 1'b0;
        ram_addrb = widx_b[ADDR_W-1:0];
        ram_dinb  = '0;
        w_bytes   = (int'(wcnt_q) * N) / 8;
        c_bytes   = (int'(ccnt_q) * N) / 8;
        // Partial registers left-justified, trimmed to whole bytes.
        word_tail = (word_sr_q << (DATA_SIZE - int'(wcnt_q) * N))
                  & ({DATA_SIZE{1'b1}} << (DATA_SIZE - w_bytes * 8));
        cks_tail  = (cks_sr_q << (CKSUM_W - int'(ccnt_q) * N))
                  & (16'hFFFF << (CKSUM_W - c_bytes * 8));
        frame_done_d = (state_q == RECV) && !axiiv;

        if (axiiv) begin
            word_sr_d = (word_sr_q << N) | DATA_SIZE'(axiid);
            if (wcnt_b == CNT_W'(WORD_CHUNKS - 1)) begin
                wcnt_d = '0;
                if (widx_b < DEPTH_IDX) begin
                    ram_web  = 1'b1;
                    ram_dinb = word_sr_d;
                    widx_d   = widx_b + IDX_W'(1);
                    len_d    = len_b + 16'(WORD_BYTES);
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                wcnt_d = wcnt_b + CNT_W'(1);
            end

            cks_sr_d = (cks_sr_q << N) | CKSUM_W'(axiid);
            if (ccnt_b == CNT_W'(CKS_CHUNKS - 1)) begin
                ccnt_d = '0;
                sum_d  = cksum_add(sum_b, cks_sr_d);
            end else begin
                ccnt_d = ccnt_b + CNT_W'(1);
            end
        end else if (state_q == RECV) begin
            wcnt_d = '0;
            ccnt_d = '0;
            if (w_bytes != 0) begin
                if (widx_b < DEPTH_IDX) begin
                    ram_web  = 1'b1;
                    ram_dinb = word_tail;
                    widx_d   = widx_b + IDX_W'(1);
                    len_d    = len_b + 16'(w_bytes);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            sum_d = cksum_add(sum_b, cks_tail);
        end
    end

    // Drain: issue one address per cycle; valid/last ride a two-stage pipe
    // matching the BRAM read latency.
    always_comb begin
        rd_idx_d = rd_idx_q;
        ram_ena  = 1'b0;
        vld1_d   = 1'b0;
        last1_d  = 1'b0;
        if (state_q == DONE && state_d == READ) begin
            rd_idx_d = '0;
        end else if (state_q == READ && state_d == READ && rd_idx_q < widx_q) begin
            ram_ena  = 1'b1;
            vld1_d   = 1'b1;
            last1_d  = (rd_idx_q == widx_q - IDX_W'(1));
            rd_idx_d = rd_idx_q + IDX_W'(1);
        end
        vld2_d  = vld1_q && (state_d == READ);
        last2_d = last1_q && (state_d == READ);
    end

    // A frame starting mid-drain drops valid combinationally in that cycle.
    always_comb begin
        axiov    = (state_q == READ) && vld2_q && !axiiv;
        axi_last = axiov && last2_q;
        axiod    = axiov ? ram_douta : '0;
    end

    assign frame_done  = frame_done_q;
    assign data_sum    = sum_q;
    assign data_length = len_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_data_store_rx.sv
// Directed frames with a scoreboard: stimulus pushes expected frame results
// and drained words; a negedge monitor pops and compares as the DUT emits them.
module tb_data_store_rx;

    logic        clk;
    logic        rst;
    logic        axiiv;
    logic [1:0]  axiid;
    logic        read_request;
    logic        axiov;
    logic [15:0] axiod;
    logic        axi_last;
    logic        frame_done;
    logic [15:0] data_sum;
    logic [15:0] data_length;
    logic        overflow;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } word_exp_t;

    typedef struct {
        logic [15:0] len;
        logic [15:0] sum;
        logic        ovf;
    } res_exp_t;

    word_exp_t exp_word_q[$];
    res_exp_t  exp_res_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int words_exp = 0, words_seen = 0;
    int frames_exp = 0, frames_seen = 0;

    data_store_rx #(.N(2), .DATA_SIZE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .axiiv       (axiiv),
        .axiid       (axiid),
        .read_request(read_request),
        .axiov       (axiov),
        .axiod       (axiod),
        .axi_last    (axi_last),
        .frame_done  (frame_done),
        .data_sum    (data_sum),
        .data_length (data_length),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input int got, input int req);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0d, required %0d", name, got, req);
    endtask

    // Monitor: every emitted word or frame_done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rst) begin
            if (axiov) begin
                if (exp_word_q.size() == 0) begin
                    flag("unexpected_axiov", 1, 0);
                end else begin
                    word_exp_t e;
                    e = exp_word_q.pop_front();
                    check("axiod", 32'(axiod), 32'(e.data));
                    check("axi_last", 32'(axi_last), 32'(e.last));
                end
                words_seen++;
            end
            if (frame_done) begin
                if (exp_res_q.size() == 0) begin
                    flag("unexpected_frame_done", 1, 0);
                end else begin
                    res_exp_t r;
                    r = exp_res_q.pop_front();
                    check("data_length", 32'(data_length), 32'(r.len));
                    check("data_sum", 32'(data_sum), 32'(r.sum));
                    check("overflow", 32'(overflow), 32'(r.ovf));
                end
                frames_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_dibits(input logic [15:0] w, input int nd);
        for (int i = 0; i < nd; i++) begin
            axiiv = 1'b1;
            axiid = w[15-2*i -: 2];
            tick();
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        send_dibits(w, 8);
    endtask

    task automatic push_word(input logic [15:0] d, input logic last);
        word_exp_t e;
        e.data = d;
        e.last = last;
        exp_word_q.push_back(e);
        words_exp++;
    endtask

    task automatic push_res(input logic [15:0] len, input logic [15:0] sum, input logic ovf);
        res_exp_t r;
        r.len = len;
        r.sum = sum;
        r.ovf = ovf;
        exp_res_q.push_back(r);
        frames_exp++;
    endtask

    task automatic wait_frames(input int budget);
        int n = 0;
        while (frames_seen != frames_exp && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_checks++;
        if (frames_seen != frames_exp) begin
            n_fail++;
            $display("FAIL wait_frame_done: seen %0d, required %0d", frames_seen, frames_exp);
        end
    endtask

    task automatic wait_words(input int budget);
        int n = 0;
        while (words_seen != words_exp && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_checks++;
        if (words_seen != words_exp) begin
            n_fail++;
            $display("FAIL wait_words: seen %0d, required %0d", words_seen, words_exp);
        end
    endtask

    task automatic end_frame();
        axiiv = 1'b0;
        axiid = 2'b00;
        tick();
        wait_frames(10);
    endtask

    task automatic drain(input int budget);
        read_request = 1'b1;
        tick();
        read_request = 1'b0;
        wait_words(budget);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_axiov"}, 32'(axiov), 32'h0);
        check({tag, "_axiod"}, 32'(axiod), 32'h0);
        check({tag, "_axi_last"}, 32'(axi_last), 32'h0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
        check({tag, "_data_sum"}, 32'(data_sum), 32'h0);
        check({tag, "_data_length"}, 32'(data_length), 32'h0);
        check({tag, "_overflow"}, 32'(overflow), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        axiiv        = 1'b0;
        axiid        = 2'b00;
        read_request = 1'b0;
        repeat (3) tick();
        check_all_zero("in_reset");
        rst = 1'b1;
        tick();
        check_all_zero("after_reset");

        // Basic frame, then a replay of the same drain.
        push_res(16'd4, 16'hBE01, 1'b0);
        send_word(16'h1234);
        send_word(16'hABCD);
        end_frame();
        push_word(16'h1234, 1'b0);
        push_word(16'hABCD, 1'b1);
        drain(20);
        push_word(16'h1234, 1'b0);
        push_word(16'hABCD, 1'b1);
        drain(20);

        // End-around carry.
        push_res(16'd4, 16'h0002, 1'b0);
        send_word(16'hFFFF);
        send_word(16'h0002);
        end_frame();
        push_word(16'hFFFF, 1'b0);
        push_word(16'h0002, 1'b1);
        drain(20);

        // Odd length with a stray trailing dibit.
        push_res(16'd3, 16'h6834, 1'b0);
        send_word(16'h1234);
        send_dibits(16'h5600, 4);
        send_dibits(16'hC000, 1);
        end_frame();
        push_word(16'h1234, 1'b0);
        push_word(16'h5600, 1'b1);
        drain(20);

        // Overflow: 256 counting words then one extra zero word.
        push_res(16'd512, 16'h7F80, 1'b1);
        for (int i = 0; i < 256; i++) send_word(16'(i));
        send_word(16'h0000);
        end_frame();
        for (int i = 0; i < 256; i++) push_word(16'(i), i == 255);
        drain(300);

        // No complete byte: no words stored, read_request is ignored, overflow cleared.
        push_res(16'd0, 16'h0000, 1'b0);
        send_dibits(16'h8000, 1);
        end_frame();
        read_request = 1'b1;
        tick();
        read_request = 1'b0;
        repeat (6) tick();
        check("empty_frame_axiov", 32'(axiov), 32'h0);

        // Interrupted drain.
        push_res(16'd10, 16'hFFFF, 1'b0);
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        send_word(16'h4444);
        send_word(16'h5555);
        end_frame();
        push_word(16'h1111, 1'b0);
        push_word(16'h2222, 1'b0);
        push_word(16'h3333, 1'b0);
        drain(20);
        push_res(16'd2, 16'hBEEF, 1'b0);
        axiiv = 1'b1;
        axiid = 2'b10;
        #1;
        check("abort_axiov", 32'(axiov), 32'h0);
        check("abort_axi_last", 32'(axi_last), 32'h0);
        tick();
        send_dibits(16'h3EEF << 2, 7);
        end_frame();
        push_word(16'hBEEF, 1'b1);
        drain(20);

        // Asynchronous reset in the middle of a frame.
        send_word(16'h1234);
        send_dibits(16'h5000, 3);
        check("pre_reset_data_length", 32'(data_length), 32'd2);
        rst   = 1'b0;
        axiiv = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        rst = 1'b1;
        repeat (5) tick();
        push_res(16'd2, 16'hCAFE, 1'b0);
        send_word(16'hCAFE);
        end_frame();
        push_word(16'hCAFE, 1'b1);
        drain(20);

        repeat (4) tick();
        check("words_left", 32'(exp_word_q.size()), 32'd0);
        check("frames_left", 32'(exp_res_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
